// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the multi-cycle ALU slice.
//   - opcode constants (OP_ADD .. OP_ROLN); 0 and 13-15 are invalid
//   - FSM state encoding (ST_IDLE, ST_EXEC, ST_DONE)
//   - bit positions of the result flags inside the registered flag vector
package alu_pkg;

    localparam int OPCODE_W = 4;

    localparam logic [OPCODE_W-1:0] OP_ADD  = 4'd1;
    localparam logic [OPCODE_W-1:0] OP_ADC  = 4'd2;
    localparam logic [OPCODE_W-1:0] OP_SUB  = 4'd3;
    localparam logic [OPCODE_W-1:0] OP_INC  = 4'd4;
    localparam logic [OPCODE_W-1:0] OP_DEC  = 4'd5;
    localparam logic [OPCODE_W-1:0] OP_AND  = 4'd6;
    localparam logic [OPCODE_W-1:0] OP_NOT  = 4'd7;
    localparam logic [OPCODE_W-1:0] OP_ROR  = 4'd8;
    localparam logic [OPCODE_W-1:0] OP_ROL  = 4'd9;
    localparam logic [OPCODE_W-1:0] OP_MUL  = 4'd10;
    localparam logic [OPCODE_W-1:0] OP_RORN = 4'd11;
    localparam logic [OPCODE_W-1:0] OP_ROLN = 4'd12;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int FLAG_CARRY   = 0;
    localparam int FLAG_BORROW  = 1;
    localparam int FLAG_ZERO    = 2;
    localparam int FLAG_PARITY  = 3;
    localparam int FLAG_INVALID = 4;
    localparam int NUM_FLAGS    = 5;

endpackage

// File: rtl/alu_mc_if.sv
// alu_mc_if: operand-issue and result-writeback handshakes of alu_mc.
//   Issue side  : in_valid/in_ready, A, B, Opcode, carry_in
//   Result side : out_valid/out_ready, Y, Y_hi, carry_out, borrow, zero,
//                 parity, invalid_Op
//   master = the environment (issue stage + writeback stage), slave = alu_mc.
interface alu_mc_if import alu_pkg::*; #(parameter int BUS_WIDTH = 8) ();

    logic                 in_valid;
    logic                 in_ready;
    logic [BUS_WIDTH-1:0] A;
    logic [BUS_WIDTH-1:0] B;
    logic [OPCODE_W-1:0]  Opcode;
    logic                 carry_in;

    logic                 out_valid;
    logic                 out_ready;
    logic [BUS_WIDTH-1:0] Y;
    logic [BUS_WIDTH-1:0] Y_hi;
    logic                 carry_out;
    logic                 borrow;
    logic                 zero;
    logic                 parity;
    logic                 invalid_Op;

    modport master (
        output in_valid, A, B, Opcode, carry_in, out_ready,
        input  in_ready, out_valid, Y, Y_hi, carry_out, borrow, zero, parity, invalid_Op
    );

    modport slave (
        input  in_valid, A, B, Opcode, carry_in, out_ready,
        output in_ready, out_valid, Y, Y_hi, carry_out, borrow, zero, parity, invalid_Op
    );

endinterface

// File: rtl/alu_core.sv
// alu_core: purely combinational datapath for the single-cycle opcodes.
//   a, b, opcode, carry_in -> y, carry_out, borrow, invalid_op
//     (opcodes 1-9; MUL/RORN/ROLN give y=0 and are finished by alu_mc)
//   res_lo, res_hi         -> zero, parity of whatever result alu_mc is
//     about to register (so the multi-cycle results share the flag logic)
module alu_core import alu_pkg::*; #(
    parameter int BUS_WIDTH = 8
) (
    input  logic [BUS_WIDTH-1:0] a,
    input  logic [BUS_WIDTH-1:0] b,
    input  logic [OPCODE_W-1:0]  opcode,
    input  logic                 carry_in,
    input  logic [BUS_WIDTH-1:0] res_lo,
    input  logic [BUS_WIDTH-1:0] res_hi,
    output logic [BUS_WIDTH-1:0] y,
    output logic                 carry_out,
    output logic                 borrow,
    output logic                 invalid_op,
    output logic                 zero,
    output logic                 parity
);

    logic [BUS_WIDTH:0] sum;

    // Opcode decode; the extra sum bit is the carry for ADD/ADC/INC.
    always_comb begin
        y          = '0;
        carry_out  = 1'b0;
        borrow     = 1'b0;
        invalid_op = 1'b0;
        sum        = '0;
        case (opcode)
            OP_ADD: begin
                sum       = {1'b0, a} + {1'b0, b};
                y         = sum[BUS_WIDTH-1:0];
                carry_out = sum[BUS_WIDTH];
            end
            OP_ADC: begin
                sum       = {1'b0, a} + {1'b0, b} + {{BUS_WIDTH{1'b0}}, carry_in};
                y         = sum[BUS_WIDTH-1:0];
                carry_out = sum[BUS_WIDTH];
            end
            OP_SUB: begin
                y      = a - b;
                borrow = (a < b);
            end
            OP_INC: begin
                sum       = {1'b0, a} + {{BUS_WIDTH{1'b0}}, 1'b1};
                y         = sum[BUS_WIDTH-1:0];
                carry_out = sum[BUS_WIDTH];
            end
            OP_DEC: begin
                y      = a - {{(BUS_WIDTH-1){1'b0}}, 1'b1};
                borrow = (a == '0);
            end
            OP_AND:  y = a & b;
            OP_NOT:  y = ~a;
            OP_ROR:  y = {a[0], a[BUS_WIDTH-1:1]};
            OP_ROL:  y = {a[BUS_WIDTH-2:0], a[BUS_WIDTH-1]};
            OP_MUL, OP_RORN, OP_ROLN: ;
            default: invalid_op = 1'b1;
        endcase
    end

    assign zero   = ({res_hi, res_lo} == '0);
    assign parity = ^res_lo;

endmodule

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU, one operation in flight.
//   clk, rst : rising-edge clock, synchronous active-high reset
//   bus      : alu_mc_if.slave (operand handshake in, result handshake out)
// Single-cycle opcodes come from alu_core and are registered on the
// accepting edge. MUL runs BUS_WIDTH shift-add steps, RORN/ROLN run
// (B mod BUS_WIDTH) one-bit rotate steps; the final step is written straight
// into the result registers. BUS_WIDTH must be a power of two, >= 2.
module alu_mc import alu_pkg::*; #(
    parameter int BUS_WIDTH = 8
) (
    input logic     clk,
    input logic     rst,
    alu_mc_if.slave bus
);

    localparam int SHW = $clog2(BUS_WIDTH);
    localparam int CW  = SHW + 1;

    state_t               state, next_state;
    logic [CW-1:0]        count;
    logic [OPCODE_W-1:0]  op_q;
    logic [BUS_WIDTH-1:0] mcand, mul_hi, mul_lo, rot;
    logic [BUS_WIDTH-1:0] y_q, y_hi_q;
    logic [NUM_FLAGS-1:0] flags_q;

    logic [BUS_WIDTH-1:0] core_y;
    logic                 core_carry, core_borrow, core_invalid, res_zero, res_parity;
    logic [BUS_WIDTH-1:0] wr_y, wr_y_hi;
    logic                 wr_carry, wr_borrow, wr_invalid, write_out;
    logic                 accept, is_rot_in, last_step;
    logic [SHW-1:0]       rot_n;
    logic [BUS_WIDTH:0]   mul_sum;
    logic [BUS_WIDTH-1:0] mul_hi_nx, mul_lo_nx, rot_nx;

    // Power-of-two width makes "B mod BUS_WIDTH" just the low bits of B.
    assign rot_n     = bus.B[SHW-1:0];
    assign accept    = bus.in_valid && (state == ST_IDLE);
    assign is_rot_in = (bus.Opcode == OP_RORN) || (bus.Opcode == OP_ROLN);
    assign last_step = (count == CW'(1));

    // One shift-add step: {mul_hi, mul_lo} is the partial product with the
    // unconsumed multiplier bits in the low half, shifted right each step.
    assign mul_sum   = {1'b0, mul_hi} + (mul_lo[0] ? {1'b0, mcand} : '0);
    assign mul_hi_nx = mul_sum[BUS_WIDTH:1];
    assign mul_lo_nx = {mul_sum[0], mul_lo[BUS_WIDTH-1:1]};
    assign rot_nx    = (op_q == OP_RORN) ? {rot[0], rot[BUS_WIDTH-1:1]}
                                         : {rot[BUS_WIDTH-2:0], rot[BUS_WIDTH-1]};

    alu_core #(.BUS_WIDTH(BUS_WIDTH)) u_core (
        .a          (bus.A),
        .b          (bus.B),
        .opcode     (bus.Opcode),
        .carry_in   (bus.carry_in),
        .res_lo     (wr_y),
        .res_hi     (wr_y_hi),
        .y          (core_y),
        .carry_out  (core_carry),
        .borrow     (core_borrow),
        .invalid_op (core_invalid),
        .zero       (res_zero),
        .parity     (res_parity)
    );

    // Next state plus the value to be written into the result registers.
    // A result is written either on the accepting edge (single-cycle ops and
    // zero-length rotates) or on the last EXEC step.
    always_comb begin
        next_state = state;
        write_out  = 1'b0;
        wr_y       = '0;
        wr_y_hi    = '0;
        wr_carry   = 1'b0;
        wr_borrow  = 1'b0;
        wr_invalid = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if ((bus.Opcode == OP_MUL) || (is_rot_in && (rot_n != '0))) begin
                        next_state = ST_EXEC;
                    end else begin
                        next_state = ST_DONE;
                        write_out  = 1'b1;
                        if (is_rot_in) begin
                            wr_y = bus.A;
                        end else begin
                            wr_y       = core_y;
                            wr_carry   = core_carry;
                            wr_borrow  = core_borrow;
                            wr_invalid = core_invalid;
                        end
                    end
                end
            end
            ST_EXEC: begin
                if (last_step) begin
                    next_state = ST_DONE;
                    write_out  = 1'b1;
                    if (op_q == OP_MUL) begin
                        wr_y     = mul_lo_nx;
                        wr_y_hi  = mul_hi_nx;
                        wr_carry = (mul_hi_nx != '0);
                    end else begin
                        wr_y = rot_nx;
                    end
                end
            end
            ST_DONE: begin
                if (bus.out_ready) next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // State, iteration registers and result registers. Operands are captured
    // on accept so later input changes cannot disturb an operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            count   <= '0;
            op_q    <= '0;
            mcand   <= '0;
            mul_hi  <= '0;
            mul_lo  <= '0;
            rot     <= '0;
            y_q     <= '0;
            y_hi_q  <= '0;
            flags_q <= '0;
        end else begin
            state <= next_state;
            if (accept) begin
                op_q   <= bus.Opcode;
                mcand  <= bus.A;
                mul_hi <= '0;
                mul_lo <= bus.B;
                rot    <= bus.A;
                count  <= (bus.Opcode == OP_MUL) ? CW'(BUS_WIDTH) : {1'b0, rot_n};
            end else if (state == ST_EXEC) begin
                count  <= count - CW'(1);
                mul_hi <= mul_hi_nx;
                mul_lo <= mul_lo_nx;
                rot    <= rot_nx;
            end
            if (write_out) begin
                y_q                   <= wr_y;
                y_hi_q                <= wr_y_hi;
                flags_q[FLAG_CARRY]   <= wr_carry;
                flags_q[FLAG_BORROW]  <= wr_borrow;
                flags_q[FLAG_ZERO]    <= res_zero & ~wr_invalid;
                flags_q[FLAG_PARITY]  <= res_parity;
                flags_q[FLAG_INVALID] <= wr_invalid;
            end
        end
    end

    assign bus.in_ready   = (state == ST_IDLE);
    assign bus.out_valid  = (state == ST_DONE);
    assign bus.Y          = y_q;
    assign bus.Y_hi       = y_hi_q;
    assign bus.carry_out  = flags_q[FLAG_CARRY];
    assign bus.borrow     = flags_q[FLAG_BORROW];
    assign bus.zero       = flags_q[FLAG_ZERO];
    assign bus.parity     = flags_q[FLAG_PARITY];
    assign bus.invalid_Op = flags_q[FLAG_INVALID];

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: self-checking bench for alu_mc (BUS_WIDTH=8).
// Directed vectors with hand-computed results, backpressure, reset during a
// MUL, then randomized operations checked against an arithmetic model.
module tb_alu_mc;
    import alu_pkg::*;

    localparam int W = 8;
    localparam int M = (1 << W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;

    typedef struct {
        int y; int y_hi; int c; int bo; int z; int p; int inv; int lat;
    } res_t;

    typedef struct {
        res_t r;
        int   acc;
    } exp_t;

    exp_t q[$];
    bit   head_seen = 0;
    res_t mon_d;

    alu_mc_if #(.BUS_WIDTH(W)) bus ();

    alu_mc #(.BUS_WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int rotr(int x, int n);
        return ((x >> n) | (x << (W - n))) & M;
    endfunction

    function automatic int rotl(int x, int n);
        return ((x << n) | (x >> (W - n))) & M;
    endfunction

    // Reference behaviour straight from the opcode table.
    function automatic res_t model(int op, int a, int b, int cin);
        res_t r;
        int   n;
        int   prod;
        r = '{default: 0};
        r.lat = 1;
        n = b % W;
        case (op)
            1:  begin r.y = (a + b) & M;       r.c = ((a + b) > M) ? 1 : 0; end
            2:  begin r.y = (a + b + cin) & M; r.c = ((a + b + cin) > M) ? 1 : 0; end
            3:  begin r.y = (a - b) & M;       r.bo = (a < b) ? 1 : 0; end
            4:  begin r.y = (a + 1) & M;       r.c = ((a + 1) > M) ? 1 : 0; end
            5:  begin r.y = (a - 1) & M;       r.bo = (a == 0) ? 1 : 0; end
            6:  r.y = a & b;
            7:  r.y = (~a) & M;
            8:  r.y = rotr(a, 1);
            9:  r.y = rotl(a, 1);
            10: begin
                prod   = a * b;
                r.y    = prod & M;
                r.y_hi = prod >> W;
                r.c    = (r.y_hi != 0) ? 1 : 0;
                r.lat  = W + 1;
            end
            11: begin r.y = rotr(a, n); r.lat = n + 1; end
            12: begin r.y = rotl(a, n); r.lat = n + 1; end
            default: r.inv = 1;
        endcase
        if (r.inv == 0) begin
            r.z = (r.y == 0 && r.y_hi == 0) ? 1 : 0;
            r.p = $countones(r.y) % 2;
        end
        return r;
    endfunction

    function automatic res_t mk(int y, int hi, int c, int bo, int z, int p, int inv, int lat);
        res_t r;
        r.y = y; r.y_hi = hi; r.c = c; r.bo = bo; r.z = z; r.p = p; r.inv = inv; r.lat = lat;
        return r;
    endfunction

    function automatic res_t sample_dut();
        res_t r;
        r.y    = int'(bus.Y);
        r.y_hi = int'(bus.Y_hi);
        r.c    = int'(bus.carry_out);
        r.bo   = int'(bus.borrow);
        r.z    = int'(bus.zero);
        r.p    = int'(bus.parity);
        r.inv  = int'(bus.invalid_Op);
        r.lat  = 0;
        return r;
    endfunction

    task automatic cmp(string name, int got, int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic fail_now(string name);
        n_cmp++;
        n_err++;
        $display("[TB] FAIL %s: got timeout, expected handshake (t=%0t)", name, $time);
    endtask

    task automatic checkOutput(string name, res_t got, res_t exp, bit with_lat);
        cmp({name, " Y"},          got.y,    exp.y);
        cmp({name, " Y_hi"},       got.y_hi, exp.y_hi);
        cmp({name, " carry_out"},  got.c,    exp.c);
        cmp({name, " borrow"},     got.bo,   exp.bo);
        cmp({name, " zero"},       got.z,    exp.z);
        cmp({name, " parity"},     got.p,    exp.p);
        cmp({name, " invalid_Op"}, got.inv,  exp.inv);
        if (with_lat) cmp({name, " latency"}, got.lat, exp.lat);
    endtask

    // Continuous monitor: every cycle out of reset, in_ready must match
    // "nothing pending", and a presented result must match the oldest
    // accepted operation's model result and latency.
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            head_seen = 0;
        end else begin
            cmp("mon in_ready", int'(bus.in_ready), (q.size() == 0) ? 1 : 0);
            if (bus.out_valid) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("[TB] FAIL mon spurious: got out_valid=1, expected 0 (t=%0t)", $time);
                end else begin
                    if (!head_seen) begin
                        cmp("mon latency", cyc - q[0].acc + 1, q[0].r.lat);
                        head_seen = 1;
                    end
                    mon_d = sample_dut();
                    checkOutput("mon", mon_d, q[0].r, 1'b0);
                    if (bus.out_ready) begin
                        void'(q.pop_front());
                        head_seen = 0;
                    end
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                exp_t e;
                e.r   = model(int'(bus.Opcode), int'(bus.A), int'(bus.B), int'(bus.carry_in));
                e.acc = cyc + 1;
                q.push_back(e);
            end
        end
    end

    // Issue one operation, scramble the inputs after accept, wait for the
    // result, optionally hold out_ready low for 'stall' cycles, hand it off.
    task automatic applyStimulus(input int op, input int a, input int b, input int cin,
                                 input int stall, output res_t got);
        int g;
        got = '{default: 0};
        bus.out_ready = (stall == 0) ? 1'b1 : 1'b0;
        g = 0;
        while (!bus.in_ready && g < 50) begin
            @(posedge clk); #1; g++;
        end
        if (!bus.in_ready) begin
            fail_now("wait in_ready");
            bus.out_ready = 1'b1;
            return;
        end
        bus.in_valid = 1'b1;
        bus.Opcode   = 4'(op);
        bus.A        = W'(a);
        bus.B        = W'(b);
        bus.carry_in = 1'(cin);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.Opcode   = 4'($urandom);
        bus.A        = W'($urandom);
        bus.B        = W'($urandom);
        bus.carry_in = 1'($urandom);
        g = 1;
        while (!bus.out_valid && g < 50) begin
            @(posedge clk); #1; g++;
        end
        if (!bus.out_valid) begin
            fail_now("wait out_valid");
            bus.out_ready = 1'b1;
            return;
        end
        got     = sample_dut();
        got.lat = g;
        repeat (stall) begin
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic directed(string name, int op, int a, int b, int cin, int stall, res_t exp);
        res_t got;
        checkOutput({"model ", name}, model(op, a, b, cin), exp, 1'b1);
        applyStimulus(op, a, b, cin, stall, got);
        checkOutput(name, got, exp, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got no finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        res_t got;
        int   g;
        int   op, a, b, cin, stall;

        bus.in_valid  = 1'b0;
        bus.A         = '0;
        bus.B         = '0;
        bus.Opcode    = '0;
        bus.carry_in  = 1'b0;
        bus.out_ready = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        cmp("reset out_valid", int'(bus.out_valid), 0);
        cmp("reset in_ready",  int'(bus.in_ready), 1);
        checkOutput("reset", sample_dut(), mk(0, 0, 0, 0, 0, 0, 0, 0), 1'b0);

        directed("ADD 200+100",   1, 200, 100, 0, 0, mk(44, 0, 1, 0, 0, 1, 0, 1));
        directed("ADC 255+0+1",   2, 255, 0,   1, 0, mk(0, 0, 1, 0, 1, 0, 0, 1));
        directed("SUB 5-8",       3, 5,   8,   0, 0, mk(253, 0, 0, 1, 0, 1, 0, 1));
        directed("INC 255",       4, 255, 0,   0, 0, mk(0, 0, 1, 0, 1, 0, 0, 1));
        directed("DEC 0",         5, 0,   0,   0, 0, mk(255, 0, 0, 1, 0, 0, 0, 1));
        directed("AND f0&3c",     6, 240, 60,  0, 0, mk(48, 0, 0, 0, 0, 0, 0, 1));
        directed("NOT 0f",        7, 15,  0,   0, 0, mk(240, 0, 0, 0, 0, 0, 0, 1));
        directed("ROR 01",        8, 1,   0,   0, 0, mk(128, 0, 0, 0, 0, 1, 0, 1));
        directed("ROL 80",        9, 128, 0,   0, 0, mk(1, 0, 0, 0, 0, 1, 0, 1));
        directed("opcode 0",      0, 7,   9,   1, 0, mk(0, 0, 0, 0, 0, 0, 1, 1));
        directed("opcode 15",     15, 5,  3,   0, 0, mk(0, 0, 0, 0, 0, 0, 1, 1));
        directed("MUL 200*200",   10, 200, 200, 0, 0, mk(64, 156, 1, 0, 0, 1, 0, 9));
        directed("MUL 0*77",      10, 0,  77,  0, 0, mk(0, 0, 0, 0, 1, 0, 0, 9));
        directed("MUL 255*255",   10, 255, 255, 0, 1, mk(1, 254, 1, 0, 0, 1, 0, 9));
        directed("RORN 01 by 3",  11, 1,  3,   0, 0, mk(32, 0, 0, 0, 0, 1, 0, 4));
        directed("RORN 01 by 8",  11, 1,  8,   0, 0, mk(1, 0, 0, 0, 0, 1, 0, 1));
        directed("ROLN 81 by 1",  12, 129, 1,  0, 2, mk(3, 0, 0, 0, 0, 0, 0, 2));
        directed("ROLN 01 by 7",  12, 1,  7,   0, 0, mk(128, 0, 0, 0, 0, 1, 0, 8));

        // Backpressure: result must hold while out_ready stays low.
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.Opcode    = 4'd1;
        bus.A         = 8'd200;
        bus.B         = 8'd100;
        bus.carry_in  = 1'b0;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        g = 1;
        while (!bus.out_valid && g < 50) begin
            @(posedge clk); #1; g++;
        end
        cmp("bp latency", g, 1);
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'($urandom);
            bus.Opcode   = 4'($urandom);
            bus.A        = W'($urandom);
            bus.B        = W'($urandom);
            @(posedge clk); #1;
            cmp("bp Y", int'(bus.Y), 44);
            cmp("bp carry_out", int'(bus.carry_out), 1);
            cmp("bp parity", int'(bus.parity), 1);
            cmp("bp out_valid", int'(bus.out_valid), 1);
            cmp("bp in_ready", int'(bus.in_ready), 0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;

        // Reset in the fourth cycle of a MUL discards it.
        bus.in_valid = 1'b1;
        bus.Opcode   = 4'd10;
        bus.A        = 8'd200;
        bus.B        = 8'd200;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        cmp("rst-mul out_valid", int'(bus.out_valid), 0);
        cmp("rst-mul in_ready", int'(bus.in_ready), 1);
        checkOutput("rst-mul", sample_dut(), mk(0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
        repeat (W + 4) begin
            @(posedge clk); #1;
        end
        directed("ADD 1+1 after reset", 1, 1, 1, 0, 0, mk(2, 0, 0, 0, 0, 1, 0, 1));

        // Randomized operations against the model.
        for (int i = 0; i < 250; i++) begin
            op    = $urandom_range(0, 15);
            a     = $urandom_range(0, M);
            b     = $urandom_range(0, M);
            cin   = $urandom_range(0, 1);
            stall = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
            applyStimulus(op, a, b, cin, stall, got);
            checkOutput("rand", got, model(op, a, b, cin), 1'b1);
        end

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
